// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a single-cycle base integer datapath and an
// optional iterative RISC-V M-extension multiply/divide unit.
//
// Configuration macro: SEQ_ALU_MULDIV_EN
//   defined   -> MUL/DIV states and the shift-add / restoring-division
//                datapath are built; op[4]=1 requests take WIDTH+1 cycles.
//   undefined -> op[4]=1 requests complete in one cycle with data_out=0,
//                err=1, carry=0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a, b [WIDTH-1:0]    operands, captured when in_valid && in_ready
//   op [4:0]            op[4]=0: base op in op[3:0]; op[4]=1: funct3 in op[2:0]
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   out_valid/out_ready response handshake (out_valid only in DONE)
//   data_out            registered result
//   carry, zero, lt, err registered flags, valid with out_valid
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             lt,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef SEQ_ALU_MULDIV_EN
    ,
    MUL  = 2'd2,
    DIV  = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] base_res_s;
  logic             base_carry_s;
  logic             base_err_s;
  logic             lt_in_s;

  // Single-cycle base ALU evaluated on the live request operands.
  always_comb begin
    shamt_s      = b[SHW-1:0];
    sum_s        = {1'b0, a} + {1'b0, b};
    diff_s       = {1'b0, a} - {1'b0, b};  // bit WIDTH is the borrow
    lt_in_s      = ($signed(a) < $signed(b));
    base_res_s   = {WIDTH{1'b0}};
    base_carry_s = 1'b0;
    base_err_s   = 1'b0;
    case (op[3:0])
      4'b0000: {base_carry_s, base_res_s} = sum_s;
      4'b1000: {base_carry_s, base_res_s} = diff_s;
      4'b0001: base_res_s = a << shamt_s;
      4'b0010: base_res_s = {{(WIDTH-1){1'b0}}, lt_in_s};
      4'b0011: base_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0100: base_res_s = a ^ b;
      4'b0101: base_res_s = a >> shamt_s;
      4'b1101: base_res_s = $unsigned($signed(a) >>> shamt_s);
      4'b0110: base_res_s = a | b;
      4'b0111: base_res_s = a & b;
      default: base_err_s = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Operand A is signed for MULH, MULHSU, DIV and REM.
  function automatic logic signed_a(input logic [2:0] f);
    return f[2] ? ~f[0] : ((f == 3'b001) || (f == 3'b010));
  endfunction

  // Operand B is signed for MULH, DIV and REM.
  function automatic logic signed_b(input logic [2:0] f);
    return f[2] ? ~f[0] : (f == 3'b001);
  endfunction

  // acc holds {hi, lo}: product for MUL, {remainder, quotient} for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2:0]         fn_q, fn_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   hi_s, lo_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic               a_neg_s, b_neg_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mul_res_s, quo_s, rem_s, div_res_s;
  logic               last_s, lt_op_s;

  // Iteration step and final sign correction for the mul/div unit.
  always_comb begin
    a_mag_s     = (signed_a(op[2:0]) && a[WIDTH-1]) ? -a : a;
    b_mag_s     = (signed_b(op[2:0]) && b[WIDTH-1]) ? -b : b;
    hi_s        = acc_q[2*WIDTH-1:WIDTH];
    lo_s        = acc_q[WIDTH-1:0];
    // Shift-add: conditionally add multiplicand to hi, shift right by one.
    mul_sum_s   = {1'b0, hi_s} + (lo_s[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, lo_s[WIDTH-1:1]};
    // Restoring division: shift next dividend bit into the remainder.
    div_shift_s = {hi_s, lo_s[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
    div_diff_s  = div_shift_s[WIDTH-1:0] - mcand_q;
    div_next_s  = {(div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0]),
                   lo_s[WIDTH-2:0], div_ge_s};
    last_s      = (cnt_q == SHW'(WIDTH-1));
    lt_op_s     = ($signed(opa_q) < $signed(opb_q));
    a_neg_s     = signed_a(fn_q) && opa_q[WIDTH-1];
    b_neg_s     = signed_b(fn_q) && opb_q[WIDTH-1];
    prod_s      = (a_neg_s ^ b_neg_s) ? -mul_next_s : mul_next_s;
    mul_res_s   = (fn_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    if (opb_q == {WIDTH{1'b0}}) begin
      quo_s = {WIDTH{1'b1}};
      rem_s = opa_q;
    end else if (!fn_q[0] && (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (opb_q == {WIDTH{1'b1}})) begin
      quo_s = opa_q;
      rem_s = {WIDTH{1'b0}};
    end else begin
      quo_s = (a_neg_s ^ b_neg_s) ? -div_next_s[WIDTH-1:0] : div_next_s[WIDTH-1:0];
      rem_s = a_neg_s ? -div_next_s[2*WIDTH-1:WIDTH] : div_next_s[2*WIDTH-1:WIDTH];
    end
    div_res_s   = fn_q[1] ? rem_s : quo_s;
  end
`endif

  // Next-state and next-output logic for the request/response FSM.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    lt_d       = lt_q;
    err_d      = err_q;
`ifdef SEQ_ALU_MULDIV_EN
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    fn_d       = fn_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!op[4]) begin
            data_out_d = base_res_s;
            carry_d    = base_carry_s;
            zero_d     = (base_res_s == {WIDTH{1'b0}});
            lt_d       = lt_in_s;
            err_d      = base_err_s;
            state_d    = DONE;
          end else begin
`ifdef SEQ_ALU_MULDIV_EN
            opa_d = a;
            opb_d = b;
            fn_d  = op[2:0];
            cnt_d = {SHW{1'b0}};
            if (op[2]) begin
              acc_d   = {{WIDTH{1'b0}}, a_mag_s};
              mcand_d = b_mag_s;
              state_d = DIV;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, b_mag_s};
              mcand_d = a_mag_s;
              state_d = MUL;
            end
`else
            data_out_d = {WIDTH{1'b0}};
            carry_d    = 1'b0;
            zero_d     = 1'b1;
            lt_d       = lt_in_s;
            err_d      = 1'b1;
            state_d    = DONE;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      MUL: begin
        acc_d = mul_next_s;
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (last_s) begin
          data_out_d = mul_res_s;
          carry_d    = 1'b0;
          zero_d     = (mul_res_s == {WIDTH{1'b0}});
          lt_d       = lt_op_s;
          err_d      = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DIV: begin
        acc_d = div_next_s;
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (last_s) begin
          data_out_d = div_res_s;
          carry_d    = 1'b0;
          zero_d     = (div_res_s == {WIDTH{1'b0}});
          lt_d       = lt_op_s;
          err_d      = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = DIV;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out_q <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      lt_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      acc_q      <= {(2*WIDTH){1'b0}};
      mcand_q    <= {WIDTH{1'b0}};
      opa_q      <= {WIDTH{1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      fn_q       <= 3'b000;
      cnt_q      <= {SHW{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      lt_q       <= lt_d;
      err_q      <= err_d;
`ifdef SEQ_ALU_MULDIV_EN
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      fn_q       <= fn_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign err       = err_q;

endmodule
